// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its transmitter.
package uart_pkg;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } arb_state_t;

   localparam int DEFAULT_BUSY_TIMEOUT = 4;
   localparam int BYTE_W               = 8;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit after last_i, wrapping.
module rr_picker #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] last_i,
   output logic [$clog2(N_REQ)-1:0] idx_o,
   output logic                     vld_o
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = IW + 1;

   logic [CW-1:0] cand;

   // cand spans last_i+1 .. last_i+N_REQ, folded back into 0..N_REQ-1
   always_comb begin
      cand  = '0;
      idx_o = last_i;
      vld_o = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, last_i} + CW'(k);
         if (cand >= CW'(N_REQ)) begin
            cand = cand - CW'(N_REQ);
         end
         if (!vld_o && req_i[cand[IW-1:0]]) begin
            vld_o = 1'b1;
            idx_o = cand[IW-1:0];
         end
      end
   end
endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: flush while idle latches the byte, busy rises next cycle
// and stays high for 10 bit periods (start, 8 data LSB first, stop).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 78
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] outgoing,
   input  logic              flush,
   output logic              busy,
   output logic              tx
);
   localparam int CKW = $clog2(CLKS_PER_BIT);

   logic              busy_q, busy_d;
   logic [9:0]        shift_q, shift_d;
   logic [3:0]        bit_q, bit_d;
   logic [CKW-1:0]    ck_q, ck_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         shift_q <= '1;
         bit_q   <= '0;
         ck_q    <= '0;
      end else begin
         busy_q  <= busy_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         ck_q    <= ck_d;
      end
   end

   always_comb begin
      busy_d  = busy_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      ck_d    = ck_q;
      if (!busy_q) begin
         if (flush) begin
            busy_d  = 1'b1;
            shift_d = {1'b1, outgoing, 1'b0};
            bit_d   = '0;
            ck_d    = '0;
         end
      end else if (ck_q == CKW'(CLKS_PER_BIT - 1)) begin
         ck_d    = '0;
         shift_d = {1'b1, shift_q[9:1]};
         if (bit_q == 4'd9) begin
            busy_d = 1'b0;
         end else begin
            bit_d = bit_q + 4'd1;
         end
      end else begin
         ck_d = ck_q + CKW'(1);
      end
   end

   assign busy = busy_q;
   assign tx   = busy_q ? shift_q[0] : 1'b1;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// A grant in IDLE gives tx_flush plus ack one cycle later; tx_busy high in IDLE holds all grants off.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [8*N_REQ-1:0]       req_data,
   output logic [N_REQ-1:0]         ack,
   output logic [BYTE_W-1:0]        tx_outgoing,
   output logic                     tx_flush,
   input  logic                     tx_busy,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     active,
   output logic                     timeout_err
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   arb_state_t        state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [BYTE_W-1:0] data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [IW-1:0]     pick_idx;
   logic              pick_vld;
   logic [BYTE_W-1:0] pick_byte;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req_i  (req),
      .last_i (grant_q),
      .idx_o  (pick_idx),
      .vld_o  (pick_vld)
   );

   always_comb begin
      pick_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == IW'(i)) begin
            pick_byte = req_data[8*i +: 8];
         end
      end
   end

   // grant_q resets to the last index so requester 0 is searched first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= IW'(N_REQ - 1);
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!tx_busy && pick_vld) begin
               grant_d = pick_idx;
               data_d  = pick_byte;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            cnt_d   = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(BUSY_TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < N_REQ; i++) begin
         ack[i] = (state_q == ST_FLUSH) && (grant_q == IW'(i));
      end
   end

   assign tx_flush    = (state_q == ST_FLUSH);
   assign active      = (state_q != ST_IDLE);
   assign tx_outgoing = data_q;
   assign grant_idx   = grant_q;
   assign timeout_err = err_q;
endmodule
